// File: rtl/fold_residue_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fold_residue_reduce_pkg
// Brief    : Shared widths, default modulus, FSM encoding and STEPS legality.
// Revision : 1.0
// ============================================================================
package fold_residue_reduce_pkg;

  localparam int c_in_w  = 384;
  localparam int c_mod_w = 128;
  localparam logic [c_mod_w-1:0] c_modulus = 128'h7fffffffffffffffffffffffffffffff;

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_run  = 2'd1;
  localparam logic [1:0] c_state_done = 2'd2;

  function automatic bit steps_legal(input int steps);
    return (steps == 1) || (steps == 2) || (steps == 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fold_residue_reduce_step.sv
`default_nettype none
// ============================================================================
// Module   : mod_shift_sub_step
// Brief    : One restoring shift-compare-subtract step of the reduction.
// Revision : 1.0
// ============================================================================
module mod_shift_sub_step #(
  parameter int MOD_W = 128
) (
  input  logic [MOD_W:0]   rem_in,
  input  logic             bit_in,
  input  logic [MOD_W-1:0] modulus,
  output logic [MOD_W:0]   rem_out
);

  logic [MOD_W+1:0] w_shifted;
  logic             w_ge;

  assign w_shifted = {rem_in, bit_in};
  assign w_ge      = (w_shifted >= {2'b00, modulus});
  // rem_in < modulus on entry, so the shifted value is below 2*modulus and
  // a single conditional subtract restores the invariant.
  assign rem_out   = w_ge ? (MOD_W+1)'(w_shifted - {2'b00, modulus})
                          : w_shifted[MOD_W:0];

endmodule
`default_nettype wire

// File: rtl/fold_residue_reduce.sv
`default_nettype none
// ============================================================================
// Module   : fold_residue_reduce
// Brief    : Iterative modular reduction of the multiplier product, STEPS
//            dividend bits per cycle, with sticky drop flag.
// Revision : 1.0
// ============================================================================
module fold_residue_reduce
  import fold_residue_reduce_pkg::*;
#(
  parameter int               IN_W    = c_in_w,
  parameter int               MOD_W   = c_mod_w,
  parameter logic [MOD_W-1:0] MODULUS = c_modulus,
  parameter int               STEPS   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [MOD_W-1:0] out_data,
  output logic             overflow
);

  localparam int c_iters = IN_W / STEPS;
  localparam int c_cnt_w = (c_iters > 1) ? $clog2(c_iters) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_iters - 1);

  if (!steps_legal(STEPS) || (IN_W % STEPS) != 0 || MODULUS <= 1) begin : g_bad_params
    $error("fold_residue_reduce: illegal STEPS/IN_W/MODULUS combination");
  end

  logic [1:0]                r_state;
  logic [IN_W-1:0]           r_dividend;
  logic [MOD_W:0]            r_rem;
  logic [c_cnt_w-1:0]        r_count;
  logic                      r_out_valid;
  logic [MOD_W-1:0]          r_out_data;
  logic                      r_overflow;
  logic [STEPS:0][MOD_W:0]   w_rem_chain;
  logic                      w_ready;

  assign w_ready        = (r_state == c_state_idle);
  assign w_rem_chain[0] = r_rem;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    mod_shift_sub_step #(.MOD_W(MOD_W)) u_step (
      .rem_in  (w_rem_chain[k]),
      .bit_in  (r_dividend[IN_W-1-k]),
      .modulus (MODULUS),
      .rem_out (w_rem_chain[k+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_state_idle;
      r_dividend  <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // Upstream cannot stall, so a busy-time operand is lost and recorded.
      if (in_valid && !w_ready) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        c_state_idle: begin
          if (in_valid) begin
            r_dividend <= in_data;
            r_rem      <= '0;
            r_count    <= c_cnt_load;
            r_state    <= c_state_run;
          end
        end
        c_state_run: begin
          r_rem      <= w_rem_chain[STEPS];
          r_dividend <= r_dividend << STEPS;
          if (r_count == '0) begin
            r_state <= c_state_done;
          end else begin
            r_count <= r_count - c_cnt_w'(1);
          end
        end
        c_state_done: begin
          r_out_data  <= r_rem[MOD_W-1:0];
          r_out_valid <= 1'b1;
          r_state     <= c_state_idle;
        end
        default: r_state <= c_state_idle;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fold_residue_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_fold_residue_reduce
// Brief    : Scoreboard bench for STEPS=1 and STEPS=2 reducers.
// Revision : 1.0
// ============================================================================
module tb_fold_residue_reduce;

  localparam int c_in_w  = 384;
  localparam int c_mod_w = 128;
  localparam logic [127:0] c_mod = 128'h7fffffffffffffffffffffffffffffff;
  localparam int c_lat0 = c_in_w / 1 + 1;
  localparam int c_lat1 = c_in_w / 2 + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iv0 = 1'b0, iv1 = 1'b0;
  logic [383:0] id0 = '0, id1 = '0;
  logic rdy0, rdy1, ov0, ov1, of0, of1;
  logic [127:0] od0, od1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic exp_ovf0 = 1'b0, exp_ovf1 = 1'b0;
  logic prev_ov0 = 1'b0, prev_ov1 = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  fold_residue_reduce #(.IN_W(c_in_w), .MOD_W(c_mod_w), .MODULUS(c_mod), .STEPS(1)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(iv0), .in_data(id0),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .overflow(of0)
  );

  fold_residue_reduce #(.IN_W(c_in_w), .MOD_W(c_mod_w), .MODULUS(c_mod), .STEPS(2)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_data(id1),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .overflow(of1)
  );

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] v = '0;
    for (int i = 0; i < 12; i++) v = {v[351:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [127:0] model(input logic [383:0] x);
    logic [383:0] m = {256'd0, c_mod};
    logic [383:0] r = x % m;
    return r[127:0];
  endfunction

  task automatic send(input int sel, input logic [383:0] d, input logic [127:0] e, output int acc);
    int   g = 0;
    exp_t ent;
    acc = -1;
    @(negedge clock);
    while (!(sel == 0 ? rdy0 : rdy1) && g < 2000) begin
      @(negedge clock);
      g++;
    end
    if (g >= 2000) begin
      fail("ready_timeout");
      return;
    end
    if (sel == 0) begin iv0 = 1'b1; id0 = d; end
    else          begin iv1 = 1'b1; id1 = d; end
    @(posedge clock);
    #1;
    acc = cyc;
    ent.data = e;
    if (sel == 0) begin
      iv0 = 1'b0;
      ent.cyc = cyc + c_lat0;
      q0.push_back(ent);
    end else begin
      iv1 = 1'b0;
      ent.cyc = cyc + c_lat1;
      q1.push_back(ent);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 3000) begin
      @(negedge clock);
      g++;
    end
    if (q0.size() != 0 || q1.size() != 0) fail("drain_timeout");
  endtask

  // Monitors: pop expected results whenever a DUT presents out_valid.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_ov0 = 1'b0;
    end else begin
      if (prev_ov0) chk("out_valid_width0", 384'(ov0), 384'd0);
      if (ov0) begin
        if (q0.size() == 0) fail("unexpected_out_valid0");
        else begin
          e = q0.pop_front();
          chk("out_data0", 384'(od0), 384'(e.data));
          chk("latency0", 384'(cyc), 384'(e.cyc));
          chk("overflow_at_result0", 384'(of0), 384'(exp_ovf0));
        end
      end
      prev_ov0 = ov0;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_ov1 = 1'b0;
    end else begin
      if (prev_ov1) chk("out_valid_width1", 384'(ov1), 384'd0);
      if (ov1) begin
        if (q1.size() == 0) fail("unexpected_out_valid1");
        else begin
          e = q1.pop_front();
          chk("out_data1", 384'(od1), 384'(e.data));
          chk("latency1", 384'(cyc), 384'(e.cyc));
          chk("overflow_at_result1", 384'(of1), 384'(exp_ovf1));
        end
      end
      prev_ov1 = ov1;
    end
  end

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [383:0] all_ones;
    logic [383:0] x, y;
    int a0, a1, t;

    all_ones = '1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready0", 384'(rdy0), 384'd1);
    chk("reset_out_valid0", 384'(ov0), 384'd0);
    chk("reset_out_data0", 384'(od0), 384'd0);
    chk("reset_overflow0", 384'(of0), 384'd0);
    chk("reset_in_ready1", 384'(rdy1), 384'd1);
    chk("reset_out_data1", 384'(od1), 384'd0);
    reset = 1'b0;

    fork
      begin
        send(0, 384'd0, 128'd0, t);
        send(0, {256'd0, c_mod}, 128'd0, t);
        send(0, 384'd1 << 127, 128'd1, t);
        send(0, all_ones, 128'd7, t);
        send(0, 384'd1 << 128, 128'd2, t);
        send(0, 384'd1 << 254, 128'd1, t);
        x = rand384();
        y = rand384();
        send(0, x, model(x), a0);
        send(0, y, model(y), a1);
        chk("back_to_back_spacing0", 384'(a1 - a0), 384'(c_in_w + 2));
      end
      begin
        send(1, all_ones, 128'd7, t);
        send(1, 384'd1 << 127, 128'd1, t);
        x = rand384();
        send(1, x, model(x), a0);
        send(1, 384'd5, 128'd5, a1);
        chk("back_to_back_spacing1", 384'(a1 - a0), 384'(c_in_w / 2 + 2));
      end
    join
    drain();

    // Dropped operand while busy.
    x = rand384();
    send(0, x, model(x), t);
    repeat (50) @(negedge clock);
    iv0 = 1'b1;
    id0 = rand384();
    exp_ovf0 = 1'b1;
    @(negedge clock);
    iv0 = 1'b0;
    chk("overflow_set0", 384'(of0), 384'd1);
    chk("overflow_isolated1", 384'(of1), 384'd0);
    y = rand384();
    send(0, y, model(y), t);
    drain();
    chk("overflow_sticky0", 384'(of0), 384'd1);

    // Reset in the middle of RUN aborts the operation.
    x = rand384();
    send(0, x, model(x), t);
    repeat (99) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q0.delete();
    exp_ovf0 = 1'b0;
    @(negedge clock);
    chk("midrun_reset_in_ready", 384'(rdy0), 384'd1);
    chk("midrun_reset_out_data", 384'(od0), 384'd0);
    chk("midrun_reset_out_valid", 384'(ov0), 384'd0);
    chk("midrun_reset_overflow", 384'(of0), 384'd0);
    y = rand384();
    send(0, y, model(y), t);
    drain();
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
